// File: rtl/light_sequencer.sv
// light_sequencer
//   Drives the sel/button inputs of the downstream lights_selector block.
//   While idle, the manual requester owns the outputs (one-cycle registered
//   copy of man_sel_i/man_btn_i). An accepted start hands ownership to the
//   show engine, which holds sel high and emits one-cycle button pulses every
//   dwell cycles, for a given number of steps (0 = run until stopped).
//
//   State table
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | manual owner, waiting for start (00)
//   RUN   | show engine owns sel/button, pulsing button each dwell (01)
//   DONE  | finite run finished, one-cycle done pulse (10)
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    single-cycle request to begin an automatic run
//   stop_i     single-cycle request to abort an automatic run
//   dwell_i    cycles per step (0 is treated as 1), sampled on start
//   steps_i    pulses per run, 0 = continuous, sampled on start
//   man_sel_i  manual sel request
//   man_btn_i  manual button request
//   sel_o      to lights_selector sel
//   button_o   to lights_selector button
//   busy_o     high while in RUN
//   done_o     one-cycle pulse when a finite run completes
//   state_o    FSM state encoding
module light_sequencer #(
    parameter int DW = 16,
    parameter int SW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [DW-1:0] dwell_i,
    input  logic [SW-1:0] steps_i,
    input  logic          man_sel_i,
    input  logic          man_btn_i,
    output logic          sel_o,
    output logic          button_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e        state_q;
    logic          sel_q;
    logic          button_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] dwell_r_q;
    logic [SW-1:0] steps_r_q;
    logic [DW-1:0] dcnt_q;
    logic [SW-1:0] scnt_q;

    logic [DW-1:0] dwell_eff;
    logic [DW-1:0] dcnt_d;
    logic          final_pulse;

    assign dwell_eff = (dwell_i == '0) ? DW'(1) : dwell_i;

    // dcnt_q counts edges since the last pulse (or since the accepting edge),
    // so the pulse is registered on the edge where the count reaches dwell.
    assign dcnt_d = dcnt_q + DW'(1);

    // The pulse currently on button_o is the last one of a finite run.
    assign final_pulse = (steps_r_q != '0) && button_q && (scnt_q == steps_r_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            button_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dwell_r_q <= '0;
            steps_r_q <= '0;
            dcnt_q    <= '0;
            scnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && !stop_i) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        sel_q     <= 1'b1;
                        dwell_r_q <= dwell_eff;
                        steps_r_q <= steps_i;
                        // The accepting edge already counts as the first dwell
                        // cycle, so a dwell of 1 pulses immediately and keeps
                        // button high for the whole run.
                        if (dwell_eff == DW'(1)) begin
                            button_q <= 1'b1;
                            dcnt_q   <= '0;
                            scnt_q   <= SW'(1);
                        end else begin
                            button_q <= 1'b0;
                            dcnt_q   <= DW'(1);
                            scnt_q   <= '0;
                        end
                    end else begin
                        sel_q    <= man_sel_i;
                        button_q <= man_btn_i;
                    end
                end
                S_RUN: begin
                    if (stop_i) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        sel_q    <= man_sel_i;
                        button_q <= 1'b0;
                        dcnt_q   <= '0;
                    end else if (final_pulse) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        sel_q    <= 1'b0;
                        button_q <= 1'b0;
                        dcnt_q   <= '0;
                    end else if (dcnt_d == dwell_r_q) begin
                        button_q <= 1'b1;
                        dcnt_q   <= '0;
                        scnt_q   <= scnt_q + SW'(1);
                    end else begin
                        button_q <= 1'b0;
                        dcnt_q   <= dcnt_d;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    sel_q    <= 1'b0;
                    button_q <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    sel_q    <= 1'b0;
                    button_q <= 1'b0;
                end
            endcase
        end
    end

    assign sel_o    = sel_q;
    assign button_o = button_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_light_sequencer.sv
module tb_light_sequencer;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        stop_i;
    logic [15:0] dwell_i;
    logic [7:0]  steps_i;
    logic        man_sel_i;
    logic        man_btn_i;
    logic        sel_o;
    logic        button_o;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  state_o;

    int total;
    int bad;
    logic saw_done;

    light_sequencer #(.DW(16), .SW(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .dwell_i   (dwell_i),
        .steps_i   (steps_i),
        .man_sel_i (man_sel_i),
        .man_btn_i (man_btn_i),
        .sel_o     (sel_o),
        .button_o  (button_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .state_o   (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".sel"},    32'(sel_o),    32'd0);
        check({tag, ".button"}, 32'(button_o), 32'd0);
        check({tag, ".busy"},   32'(busy_o),   32'd0);
        check({tag, ".done"},   32'(done_o),   32'd0);
        check({tag, ".state"},  32'(state_o),  32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_i     = 1'b1;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        dwell_i   = 16'd0;
        steps_i   = 8'd0;
        man_sel_i = 1'b1;
        man_btn_i = 1'b1;

        // 1: reset holds outputs low despite manual requests
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_reset($sformatf("rst%0d", i));
        end
        rst_i = 1'b0;
        tick();
        check("man.sel", 32'(sel_o), 32'd1);
        check("man.btn", 32'(button_o), 32'd1);
        man_sel_i = 1'b0;
        man_btn_i = 1'b0;
        tick();
        check("man.sel0", 32'(sel_o), 32'd0);

        // 2: dwell=4, steps=3 -> pulses at T+4, T+8, T+12, DONE at T+13
        dwell_i = 16'd4;
        steps_i = 8'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        dwell_i = 16'd9;
        steps_i = 8'd7;
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("t2.btn%0d", k), 32'(button_o), 32'((k % 4) == 0));
            check($sformatf("t2.busy%0d", k), 32'(busy_o), 32'd1);
            check($sformatf("t2.sel%0d", k), 32'(sel_o), 32'd1);
            tick();
        end
        check("t2.state_done", 32'(state_o), 32'd2);
        check("t2.done", 32'(done_o), 32'd1);
        check("t2.busy_done", 32'(busy_o), 32'd0);
        check("t2.btn_done", 32'(button_o), 32'd0);
        tick();
        check("t2.state_idle", 32'(state_o), 32'd0);
        check("t2.done_low", 32'(done_o), 32'd0);

        // 3: dwell=0 acts as 1
        dwell_i = 16'd0;
        steps_i = 8'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t3.btn1", 32'(button_o), 32'd1);
        check("t3.state1", 32'(state_o), 32'd1);
        tick();
        check("t3.btn2", 32'(button_o), 32'd1);
        tick();
        check("t3.state_done", 32'(state_o), 32'd2);
        check("t3.done", 32'(done_o), 32'd1);
        check("t3.btn_done", 32'(button_o), 32'd0);
        tick();
        check("t3.state_idle", 32'(state_o), 32'd0);

        // 4: continuous run, manual button ignored, stop after 23 cycles
        dwell_i = 16'd5;
        steps_i = 8'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            check($sformatf("t4.btn%0d", k), 32'(button_o), 32'((k % 5) == 0));
            check($sformatf("t4.busy%0d", k), 32'(busy_o), 32'd1);
            if (done_o) saw_done = 1'b1;
            man_btn_i = k[0];
            man_sel_i = k[1];
            if (k == 23) stop_i = 1'b1;
            tick();
        end
        stop_i = 1'b0;
        check("t4.state_idle", 32'(state_o), 32'd0);
        check("t4.busy", 32'(busy_o), 32'd0);
        check("t4.btn", 32'(button_o), 32'd0);
        check("t4.sel_man", 32'(sel_o), 32'd1);
        check("t4.done_seen", 32'(saw_done | done_o), 32'd0);
        man_btn_i = 1'b0;
        man_sel_i = 1'b0;
        tick();

        // 5a: start and stop together in IDLE
        dwell_i = 16'd3;
        steps_i = 8'd2;
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("t5a.state", 32'(state_o), 32'd0);
        check("t5a.busy", 32'(busy_o), 32'd0);

        // 5b: reset mid-run
        dwell_i = 16'd3;
        steps_i = 8'd10;
        man_sel_i = 1'b1;
        man_btn_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t5b.busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        rst_i = 1'b1;
        tick();
        check_idle_reset("t5b.rst");
        rst_i = 1'b0;
        man_sel_i = 1'b0;
        man_btn_i = 1'b0;
        tick();

        // 6: stop coincides with the only pulse of a one-step run
        dwell_i = 16'd2;
        steps_i = 8'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t6.btn1", 32'(button_o), 32'd0);
        tick();
        check("t6.btn2", 32'(button_o), 32'd1);
        check("t6.state2", 32'(state_o), 32'd1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("t6.state", 32'(state_o), 32'd0);
        check("t6.done", 32'(done_o), 32'd0);
        check("t6.busy", 32'(busy_o), 32'd0);
        tick();
        check("t6.state_after", 32'(state_o), 32'd0);
        check("t6.done_after", 32'(done_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
